median3x3_dual: RTL and testbench



---
 rtl/median3x3_dual.sv | 190 +++++++++++++++++++
 tb/tb_median3x3_dual.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/median3x3_dual.sv
// Dual-window 3x3 median filter: captures a 3x4 pixel block and returns the
// medians of columns 0..2 and 1..3 through a four-state pipeline.
module median3x3_dual #(
  parameter int PIX_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [4*PIX_W-1:0] four_pixel1,
  input  logic [4*PIX_W-1:0] four_pixel2,
  input  logic [4*PIX_W-1:0] four_pixel3,
  input  logic               nxt_data_flag,
  output logic [PIX_W-1:0]   medfilt_data_out,
  output logic [PIX_W-1:0]   medfilt_data_out2,
  output logic               medfilt_done_flag,
  output logic               data_get_flag
);

  // state | meaning
  // IDLE  | waiting for nxt_data_flag; latches the 12-pixel block
  // S1    | per window, per row: sort three pixels into lo/mi/hi
  // S2    | per window: a = max(lo), b = med(mi), c = min(hi)
  // S3    | per window: result = med(a, b, c); pulse done
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S1   = 2'd1,
    S2   = 2'd2,
    S3   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [4*PIX_W-1:0] row_bus [3];

  logic [PIX_W-1:0] pix_q [3][4];
  logic [PIX_W-1:0] pix_d [3][4];

  logic [PIX_W-1:0] lo_q [2][3];
  logic [PIX_W-1:0] lo_d [2][3];
  logic [PIX_W-1:0] mi_q [2][3];
  logic [PIX_W-1:0] mi_d [2][3];
  logic [PIX_W-1:0] hi_q [2][3];
  logic [PIX_W-1:0] hi_d [2][3];

  logic [PIX_W-1:0] a_q [2];
  logic [PIX_W-1:0] a_d [2];
  logic [PIX_W-1:0] b_q [2];
  logic [PIX_W-1:0] b_d [2];
  logic [PIX_W-1:0] c_q [2];
  logic [PIX_W-1:0] c_d [2];

  logic [PIX_W-1:0] out_q [2];
  logic [PIX_W-1:0] out_d [2];

  logic done_q, done_d;
  logic get_q, get_d;

  assign row_bus[0] = four_pixel1;
  assign row_bus[1] = four_pixel2;
  assign row_bus[2] = four_pixel3;

  function automatic logic [PIX_W-1:0] min2(input logic [PIX_W-1:0] x,
                                            input logic [PIX_W-1:0] y);
    return (x < y) ? x : y;
  endfunction

  function automatic logic [PIX_W-1:0] max2(input logic [PIX_W-1:0] x,
                                            input logic [PIX_W-1:0] y);
    return (x > y) ? x : y;
  endfunction

  function automatic logic [PIX_W-1:0] min3(input logic [PIX_W-1:0] x,
                                            input logic [PIX_W-1:0] y,
                                            input logic [PIX_W-1:0] z);
    return min2(min2(x, y), z);
  endfunction

  function automatic logic [PIX_W-1:0] max3(input logic [PIX_W-1:0] x,
                                            input logic [PIX_W-1:0] y,
                                            input logic [PIX_W-1:0] z);
    return max2(max2(x, y), z);
  endfunction

  // Median of three: the larger of min(x,y) and min(max(x,y), z).
  function automatic logic [PIX_W-1:0] med3(input logic [PIX_W-1:0] x,
                                            input logic [PIX_W-1:0] y,
                                            input logic [PIX_W-1:0] z);
    return max2(min2(x, y), min2(max2(x, y), z));
  endfunction

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    lo_d    = lo_q;
    mi_d    = mi_q;
    hi_d    = hi_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    out_d   = out_q;
    done_d  = 1'b0;
    get_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (nxt_data_flag) begin
          // Column 0 sits in the most significant slice of each row bus.
          for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
              pix_d[r][c] = row_bus[r][(3-c)*PIX_W +: PIX_W];
            end
          end
          get_d   = 1'b1;
          state_d = S1;
        end
      end

      S1: begin
        for (int w = 0; w < 2; w++) begin
          for (int r = 0; r < 3; r++) begin
            lo_d[w][r] = min3(pix_q[r][w], pix_q[r][w+1], pix_q[r][w+2]);
            mi_d[w][r] = med3(pix_q[r][w], pix_q[r][w+1], pix_q[r][w+2]);
            hi_d[w][r] = max3(pix_q[r][w], pix_q[r][w+1], pix_q[r][w+2]);
          end
        end
        state_d = S2;
      end

      S2: begin
        for (int w = 0; w < 2; w++) begin
          a_d[w] = max3(lo_q[w][0], lo_q[w][1], lo_q[w][2]);
          b_d[w] = med3(mi_q[w][0], mi_q[w][1], mi_q[w][2]);
          c_d[w] = min3(hi_q[w][0], hi_q[w][1], hi_q[w][2]);
        end
        state_d = S3;
      end

      S3: begin
        for (int w = 0; w < 2; w++) begin
          out_d[w] = med3(a_q[w], b_q[w], c_q[w]);
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      get_q   <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 4; c++) begin
          pix_q[r][c] <= '0;
        end
      end
      for (int w = 0; w < 2; w++) begin
        for (int r = 0; r < 3; r++) begin
          lo_q[w][r] <= '0;
          mi_q[w][r] <= '0;
          hi_q[w][r] <= '0;
        end
        a_q[w]   <= '0;
        b_q[w]   <= '0;
        c_q[w]   <= '0;
        out_q[w] <= '0;
      end
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      lo_q    <= lo_d;
      mi_q    <= mi_d;
      hi_q    <= hi_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      out_q   <= out_d;
      done_q  <= done_d;
      get_q   <= get_d;
    end
  end

  assign medfilt_data_out  = out_q[0];
  assign medfilt_data_out2 = out_q[1];
  assign medfilt_done_flag = done_q;
  assign data_get_flag     = get_q;

endmodule

// File: tb/tb_median3x3_dual.sv
// Directed bench for median3x3_dual: hand-computed medians for a small set of
// blocks, single-shot, back-to-back, mid-flight bus changes and abort by reset.
module tb_median3x3_dual;
  localparam int PIX_W = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [4*PIX_W-1:0] four_pixel1 = '0;
  logic [4*PIX_W-1:0] four_pixel2 = '0;
  logic [4*PIX_W-1:0] four_pixel3 = '0;
  logic               nxt_data_flag = 1'b0;
  logic [PIX_W-1:0]   medfilt_data_out;
  logic [PIX_W-1:0]   medfilt_data_out2;
  logic               medfilt_done_flag;
  logic               data_get_flag;

  median3x3_dual #(.PIX_W(PIX_W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .four_pixel1       (four_pixel1),
    .four_pixel2       (four_pixel2),
    .four_pixel3       (four_pixel3),
    .nxt_data_flag     (nxt_data_flag),
    .medfilt_data_out  (medfilt_data_out),
    .medfilt_data_out2 (medfilt_data_out2),
    .medfilt_done_flag (medfilt_done_flag),
    .data_get_flag     (data_get_flag)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit overlap_seen = 1'b0;

  logic [63:0] blk_r1 [6];
  logic [63:0] blk_r2 [6];
  logic [63:0] blk_r3 [6];
  logic [15:0] blk_m0 [6];
  logic [15:0] blk_m1 [6];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (data_get_flag && medfilt_done_flag) overlap_seen = 1'b1;
  endtask

  task automatic apply(input int i);
    four_pixel1 = blk_r1[i];
    four_pixel2 = blk_r2[i];
    four_pixel3 = blk_r3[i];
  endtask

  task automatic scramble();
    four_pixel1 = ~four_pixel1;
    four_pixel2 = 64'h0000_0000_0000_0000;
    four_pixel3 = ~four_pixel3;
  endtask

  task automatic wait_get(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!data_get_flag && n < 20);
    chk("get_seen", {31'd0, data_get_flag}, 32'd1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!medfilt_done_flag && n < 20);
    chk("done_seen", {31'd0, medfilt_done_flag}, 32'd1);
  endtask

  // One-cycle request, buses scrambled right after capture.
  task automatic run_block(input int i);
    apply(i);
    nxt_data_flag = 1'b1;
    tick();
    chk($sformatf("b%0d_get", i), {31'd0, data_get_flag}, 32'd1);
    nxt_data_flag = 1'b0;
    scramble();
    tick();
    chk($sformatf("b%0d_get_pulse", i), {31'd0, data_get_flag}, 32'd0);
    chk($sformatf("b%0d_done_early", i), {31'd0, medfilt_done_flag}, 32'd0);
    tick();
    chk($sformatf("b%0d_done_early2", i), {31'd0, medfilt_done_flag}, 32'd0);
    tick();
    chk($sformatf("b%0d_done", i), {31'd0, medfilt_done_flag}, 32'd1);
    chk($sformatf("b%0d_out", i), {16'd0, medfilt_data_out}, {16'd0, blk_m0[i]});
    chk($sformatf("b%0d_out2", i), {16'd0, medfilt_data_out2}, {16'd0, blk_m1[i]});
    tick();
    chk($sformatf("b%0d_done_pulse", i), {31'd0, medfilt_done_flag}, 32'd0);
    chk($sformatf("b%0d_out_hold", i), {16'd0, medfilt_data_out}, {16'd0, blk_m0[i]});
  endtask

  initial begin
    int n;
    int seq [4];
    bit done_seen;

    blk_r1[0] = 64'h1111_2222_3333_4444; blk_r2[0] = 64'h5555_8888_6666_7777;
    blk_r3[0] = 64'h9999_AAAA_BBBB_CCCC; blk_m0[0] = 16'h6666; blk_m1[0] = 16'h7777;
    blk_r1[1] = 64'h9999_AAAA_BBBB_CCCC; blk_r2[1] = 64'h9999_AAAA_BBBB_CCCC;
    blk_r3[1] = 64'h9999_AAAA_BBBB_CCCC; blk_m0[1] = 16'hAAAA; blk_m1[1] = 16'hBBBB;
    blk_r1[2] = 64'h0001_0002_0003_0004; blk_r2[2] = 64'h0005_0006_0007_0008;
    blk_r3[2] = 64'h0009_000A_000B_000C; blk_m0[2] = 16'h0006; blk_m1[2] = 16'h0007;
    blk_r1[3] = 64'h0009_0001_0005_0003; blk_r2[3] = 64'h0007_0002_0008_0004;
    blk_r3[3] = 64'h0006_0000_0003_FFFF; blk_m0[3] = 16'h0005; blk_m1[3] = 16'h0003;
    blk_r1[4] = 64'h8000_7FFF_8000_0001; blk_r2[4] = 64'h7FFF_8000_7FFF_FFFE;
    blk_r3[4] = 64'h8000_7FFF_0000_8000; blk_m0[4] = 16'h7FFF; blk_m1[4] = 16'h7FFF;
    blk_r1[5] = 64'h0000_0000_FFFF_1234; blk_r2[5] = 64'hFFFF_FFFF_FFFF_0001;
    blk_r3[5] = 64'hFFFF_FFFF_FFFF_0002; blk_m0[5] = 16'hFFFF; blk_m1[5] = 16'hFFFF;

    // Reset held with a pending request: nothing may be captured.
    rst_n = 1'b0;
    nxt_data_flag = 1'b1;
    apply(0);
    tick();
    tick();
    chk("rst_out", {16'd0, medfilt_data_out}, 32'd0);
    chk("rst_out2", {16'd0, medfilt_data_out2}, 32'd0);
    chk("rst_get", {31'd0, data_get_flag}, 32'd0);
    chk("rst_done", {31'd0, medfilt_done_flag}, 32'd0);
    nxt_data_flag = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("idle_no_get", {31'd0, data_get_flag}, 32'd0);
    tick();

    run_block(0);
    run_block(1);
    run_block(5);

    // Back-to-back with the request held high; buses move on after each capture.
    seq[0] = 2; seq[1] = 3; seq[2] = 4; seq[3] = 0;
    apply(seq[0]);
    nxt_data_flag = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_get(n);
      chk($sformatf("cont%0d_get_gap", k), n, 1);
      if (k < 3) apply(seq[k+1]);
      else begin
        nxt_data_flag = 1'b0;
        scramble();
      end
      wait_done(n);
      chk($sformatf("cont%0d_latency", k), n, 3);
      chk($sformatf("cont%0d_out", k), {16'd0, medfilt_data_out}, {16'd0, blk_m0[seq[k]]});
      chk($sformatf("cont%0d_out2", k), {16'd0, medfilt_data_out2}, {16'd0, blk_m1[seq[k]]});
    end
    tick();
    chk("cont_stop", {31'd0, data_get_flag}, 32'd0);

    // Abort by reset while the block sits in S2.
    apply(3);
    nxt_data_flag = 1'b1;
    tick();
    chk("abort_get", {31'd0, data_get_flag}, 32'd1);
    nxt_data_flag = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_out", {16'd0, medfilt_data_out}, 32'd0);
    chk("abort_out2", {16'd0, medfilt_data_out2}, 32'd0);
    done_seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (medfilt_done_flag) done_seen = 1'b1;
      tick();
    end
    chk("abort_no_done", {31'd0, done_seen}, 32'd0);
    chk("abort_out_hold", {16'd0, medfilt_data_out}, 32'd0);

    run_block(4);
    chk("flag_overlap", {31'd0, overlap_seen}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
